// File: rtl/serial_add_sub_if.sv
// serial_add_sub_if: start/busy/done handshake and operand/result bundle for the serial adder.
interface serial_add_sub_if #(parameter int WIDTH = 8);
    logic start, cin, sub, busy, done, cout, overflow;
    logic [WIDTH-1:0] a, b, sum;
    modport master (output start, a, b, cin, sub, input busy, done, sum, cout, overflow);
    modport slave (input start, a, b, cin, sub, output busy, done, sum, cout, overflow);
endinterface

// File: rtl/serial_add_sub.sv
// serial_add_sub: bit-serial add/subtract, LSB first, one full-adder slice over WIDTH cycles.
module serial_add_sub #(parameter int WIDTH = 8) (
    input logic clk,
    input logic rst_n,
    serial_add_sub_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t state;
    logic [WIDTH-1:0] op_a, op_b, res;
    logic [CW-1:0] cnt;
    logic carry, s, c;
    // operands are shifted right each cycle so bit cnt always sits at position 0
    assign s = op_a[0] ^ op_b[0] ^ carry;
    assign c = (op_a[0] & op_b[0]) | (op_a[0] & carry) | (op_b[0] & carry);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            op_a <= '0;
            op_b <= '0;
            res <= '0;
            cnt <= '0;
            carry <= 1'b0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
            bus.sum <= '0;
            bus.cout <= 1'b0;
            bus.overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    op_a <= bus.a;
                    op_b <= bus.sub ? ~bus.b : bus.b;
                    carry <= bus.cin ^ bus.sub;
                    res <= '0;
                    cnt <= '0;
                    bus.busy <= 1'b1;
                    state <= SHIFT;
                end
                SHIFT: begin
                    op_a <= op_a >> 1;
                    op_b <= op_b >> 1;
                    res <= {s, res[WIDTH-1:1]};
                    carry <= c;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        // carry is still the carry into the MSB here
                        bus.sum <= {s, res[WIDTH-1:1]};
                        bus.cout <= c;
                        bus.overflow <= carry ^ c;
                        bus.busy <= 1'b0;
                        bus.done <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    bus.done <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_add_sub.sv
// tb_serial_add_sub: directed and random checks of serial_add_sub at WIDTH 8, 2 and 32.
module tb_serial_add_sub;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int n_chk = 0;
    int n_fail = 0;
    always #5 clk = ~clk;
    serial_add_sub_if #(.WIDTH(8)) i8 ();
    serial_add_sub_if #(.WIDTH(2)) i2 ();
    serial_add_sub_if #(.WIDTH(32)) i32 ();
    serial_add_sub #(.WIDTH(8)) d8 (.clk(clk), .rst_n(rst_n), .bus(i8.slave));
    serial_add_sub #(.WIDTH(2)) d2 (.clk(clk), .rst_n(rst_n), .bus(i2.slave));
    serial_add_sub #(.WIDTH(32)) d32 (.clk(clk), .rst_n(rst_n), .bus(i32.slave));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input int w, input logic st, input logic [63:0] a, input logic [63:0] b,
                          input logic ci, input logic sb);
        if (w == 2) begin
            i2.start = st; i2.a = a[1:0]; i2.b = b[1:0]; i2.cin = ci; i2.sub = sb;
        end else if (w == 8) begin
            i8.start = st; i8.a = a[7:0]; i8.b = b[7:0]; i8.cin = ci; i8.sub = sb;
        end else begin
            i32.start = st; i32.a = a[31:0]; i32.b = b[31:0]; i32.cin = ci; i32.sub = sb;
        end
    endtask

    function automatic logic [63:0] get_sum(input int w);
        return w == 2 ? 64'(i2.sum) : w == 8 ? 64'(i8.sum) : 64'(i32.sum);
    endfunction

    // {busy, done, cout, overflow}
    function automatic logic [3:0] get_fl(input int w);
        return w == 2 ? {i2.busy, i2.done, i2.cout, i2.overflow} :
               w == 8 ? {i8.busy, i8.done, i8.cout, i8.overflow} :
                        {i32.busy, i32.done, i32.cout, i32.overflow};
    endfunction

    task automatic run_op(input int w, input logic [63:0] a_in, input logic [63:0] b_in,
                          input logic ci, input logic sb);
        logic [63:0] m, a, b, full, e_sum;
        logic e_c, e_v;
        longint sa, sbv, r, lim;
        int k, nb;
        m = (64'd1 << w) - 1;
        a = a_in & m;
        b = b_in & m;
        lim = longint'(1) << (w - 1);
        sa = a[w-1] ? longint'(a) - 2 * lim : longint'(a);
        sbv = b[w-1] ? longint'(b) - 2 * lim : longint'(b);
        if (sb) begin
            e_sum = (a - b - 64'(ci)) & m;
            e_c = a >= b + 64'(ci);
            r = sa - sbv - longint'(ci);
        end else begin
            full = a + b + 64'(ci);
            e_sum = full & m;
            e_c = full[w];
            r = sa + sbv + longint'(ci);
        end
        e_v = (r < -lim) || (r > lim - 1);
        @(negedge clk);
        set_in(w, 1'b1, a, b, ci, sb);
        @(posedge clk);
        #1;
        set_in(w, 1'b0, a, b, ci, sb);
        k = 1;
        nb = 0;
        while (!get_fl(w)[2] && k < 200) begin
            nb += int'(get_fl(w)[3]);
            @(posedge clk);
            #1;
            k++;
        end
        chk($sformatf("latency_w%0d", w), 64'(k), 64'(w + 1));
        chk($sformatf("busy_cycles_w%0d", w), 64'(nb), 64'(w));
        chk($sformatf("sum_w%0d", w), get_sum(w), e_sum);
        chk($sformatf("flags_w%0d", w), 64'(get_fl(w)), 64'({2'b01, e_c, e_v}));
        @(posedge clk);
        #1;
        chk($sformatf("hold_w%0d", w), {get_sum(w)[59:0], get_fl(w)}, {e_sum[59:0], 2'b00, e_c, e_v});
    endtask

    initial begin
        int k, nd;
        set_in(2, 0, 0, 0, 0, 0);
        set_in(8, 0, 0, 0, 0, 0);
        set_in(32, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out", {get_sum(8), get_fl(8)}, '0);
        @(negedge clk);
        rst_n = 1'b1;
        // 1-3: directed add/sub corner cases
        run_op(8, 'h5A, 'h33, 0, 0);
        chk("t1_sum_const", {get_sum(8), get_fl(8)[1:0]}, {64'h8D, 2'b01});
        run_op(8, 'hFF, 'h01, 0, 0);
        chk("t2a_const", {get_sum(8), get_fl(8)[1:0]}, {64'h00, 2'b10});
        run_op(8, 'h7F, 'h00, 1, 0);
        chk("t2b_const", {get_sum(8), get_fl(8)[1:0]}, {64'h80, 2'b01});
        run_op(8, 'h10, 'h20, 0, 1);
        chk("t3a_const", {get_sum(8), get_fl(8)[1:0]}, {64'hF0, 2'b00});
        run_op(8, 'h80, 'h01, 0, 1);
        chk("t3b_const", {get_sum(8), get_fl(8)[1:0]}, {64'h7F, 2'b11});
        // 4: input isolation, second start during SHIFT is dropped
        @(negedge clk);
        set_in(8, 1, 'h05, 'h03, 0, 0);
        @(posedge clk);
        #1;
        set_in(8, 0, 'h05, 'h03, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        set_in(8, 1, 'hAA, 'h55, 0, 1);
        @(posedge clk);
        #1;
        set_in(8, 0, 'hAA, 'h55, 0, 1);
        k = 4;
        while (!get_fl(8)[2] && k < 200) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("t4_latency", 64'(k), 64'd9);
        chk("t4_result", {get_sum(8), get_fl(8)[1:0]}, {64'h08, 2'b00});
        nd = 0;
        repeat (14) begin
            @(posedge clk);
            #1;
            nd += int'(get_fl(8)[2]) + int'(get_fl(8)[3]);
        end
        chk("t4_no_queued_start", 64'(nd), 64'd0);
        // 5: asynchronous reset during SHIFT cycle 4
        @(negedge clk);
        set_in(8, 1, 'h01, 'h01, 0, 0);
        @(posedge clk);
        #1;
        set_in(8, 0, 'h01, 'h01, 0, 0);
        repeat (3) @(posedge clk);
        #2;
        chk("t5_busy_before", 64'(get_fl(8)[3]), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("t5_async_clear", {get_sum(8), get_fl(8)}, '0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(8, 'h01, 'h01, 0, 0);
        chk("t5_after_reset", get_sum(8), 64'h02);
        // 6: random sweep at the width extremes plus the default width
        repeat (1000) run_op(2, 64'($urandom), 64'($urandom), 1'($urandom), 1'($urandom));
        repeat (1000) run_op(32, 64'($urandom), 64'($urandom), 1'($urandom), 1'($urandom));
        repeat (100) run_op(8, 64'($urandom), 64'($urandom), 1'($urandom), 1'($urandom));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
